// File: rtl/johnson_phase_decoder.sv
// rtl/johnson_phase_decoder.sv - phase decoder, lock tracker and revolution counter for a Johnson ring
//
// Purpose: decodes the parallel outputs of a WIDTH-stage twisted-ring counter
// into a phase index (0..2*WIDTH-1) and a one-hot phase bus. It flags illegal
// codes and illegal steps, tracks lock, counts full revolutions and strobes
// on loss of lock.
//
// Optional feature macro: JOHNSON_AUTOCORRECT_EN. When defined, a loss of lock
// caused by an illegal code pulses corr_clear_n low for one cycle. When it is
// undefined, corr_clear_n is tied high.
//
// Ports:
//   clock         rising-edge clock
//   clear         asynchronous active-low reset
//   ring_in       ring outputs; bit WIDTH-1 is the first stage
//   phase_idx     decoded phase; holds its last value on an illegal code
//   phase_onehot  one-hot of phase_idx; all zero on an illegal code
//   valid_code    last sampled code was legal
//   locked        lock status
//   wrap_pulse    one-cycle strobe when a locked revolution completes
//   rev_count     revolution counter, wraps modulo 2^REV_W
//   err_pulse     one-cycle strobe on loss of lock
//   corr_clear_n  active-low correction request to the upstream clear

module johnson_phase_decoder #(
  parameter int WIDTH      = 6,
  parameter int LOCK_COUNT = 4,
  parameter int REV_W      = 8,
  parameter int P          = 2 * WIDTH,
  parameter int PH_W       = $clog2(2 * WIDTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] ring_in,
  output logic [PH_W-1:0]  phase_idx,
  output logic [P-1:0]     phase_onehot,
  output logic             valid_code,
  output logic             locked,
  output logic             wrap_pulse,
  output logic [REV_W-1:0] rev_count,
  output logic             err_pulse,
  output logic             corr_clear_n
);

  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam logic [WIDTH-1:0] ONES = '1;

  typedef enum logic [1:0] {UNLOCKED, LOCKING, LOCKED} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] ring_q;

  logic             code_legal;
  logic [PH_W-1:0]  code_phase;
  logic [PH_W:0]    diff;
  logic             step_hold;
  logic             step_good;
  logic             step_bad;
  logic             wrap_cond;

  // Legal codes: top m bits set (phase m), or top m bits clear (phase WIDTH+m).
  always_comb begin
    code_legal = 1'b0;
    code_phase = '0;
    for (int m = 0; m <= WIDTH; m++) begin
      if (ring_q == ~(ONES >> m)) begin
        code_legal = 1'b1;
        code_phase = PH_W'(m);
      end
    end
    for (int m = 1; m < WIDTH; m++) begin
      if (ring_q == (ONES >> m)) begin
        code_legal = 1'b1;
        code_phase = PH_W'(WIDTH + m);
      end
    end
  end

  // Forward distance from the previous phase to the current one, modulo P.
  // valid_code doubles as prev_valid: it is set on a legal sample and
  // cleared on an illegal sample.
  always_comb begin
    if (code_phase >= phase_idx)
      diff = {1'b0, code_phase} - {1'b0, phase_idx};
    else
      diff = {1'b0, code_phase} + (PH_W+1)'(P) - {1'b0, phase_idx};
    step_hold = (diff == '0);
    step_good = (diff == (PH_W+1)'(1));
    step_bad  = valid_code && code_legal && !step_hold && !step_good;
    wrap_cond = step_good && (phase_idx == PH_W'(P - 1));
  end

`ifdef JOHNSON_AUTOCORRECT_EN
  logic corr_q;
  assign corr_clear_n = corr_q;
`else
  assign corr_clear_n = 1'b1;
`endif

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      ring_q       <= '0;
      state        <= UNLOCKED;
      cnt          <= '0;
      phase_idx    <= '0;
      phase_onehot <= '0;
      valid_code   <= 1'b0;
      locked       <= 1'b0;
      wrap_pulse   <= 1'b0;
      err_pulse    <= 1'b0;
      rev_count    <= '0;
`ifdef JOHNSON_AUTOCORRECT_EN
      corr_q       <= 1'b1;
`endif
    end else begin
      ring_q     <= ring_in;
      wrap_pulse <= 1'b0;
      err_pulse  <= 1'b0;
`ifdef JOHNSON_AUTOCORRECT_EN
      corr_q     <= 1'b1;
`endif
      valid_code <= code_legal;
      if (code_legal) begin
        phase_idx    <= code_phase;
        phase_onehot <= {{(P-1){1'b0}}, 1'b1} << code_phase;
      end else begin
        phase_onehot <= '0;
      end

      case (state)
        UNLOCKED: begin
          if (code_legal) begin
            state <= LOCKING;
            cnt   <= '0;
          end
        end
        LOCKING: begin
          if (!code_legal || step_bad) begin
            state <= UNLOCKED;
            cnt   <= '0;
          end else if (step_good) begin
            if (cnt == CW'(LOCK_COUNT - 1)) begin
              state  <= LOCKED;
              locked <= 1'b1;
              cnt    <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        LOCKED: begin
          if (!code_legal || step_bad) begin
            state     <= UNLOCKED;
            locked    <= 1'b0;
            cnt       <= '0;
            err_pulse <= 1'b1;
`ifdef JOHNSON_AUTOCORRECT_EN
            // Only an illegal code asks upstream to clear; bad steps do not.
            corr_q    <= code_legal;
`endif
          end else if (wrap_cond) begin
            wrap_pulse <= 1'b1;
            rev_count  <= rev_count + REV_W'(1);
          end
        end
        default: begin
          state  <= UNLOCKED;
          locked <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// tb/tb_johnson_phase_decoder.sv - self-checking bench for johnson_phase_decoder

module tb_johnson_phase_decoder;

  localparam int W  = 6;
  localparam int P  = 2 * W;
  localparam int LC = 4;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [5:0]  ring_in = '0;
  logic [3:0]  phase_idx;
  logic [11:0] phase_onehot;
  logic        valid_code;
  logic        locked;
  logic        wrap_pulse;
  logic [7:0]  rev_count;
  logic        err_pulse;
  logic        corr_clear_n;

  int total = 0;
  int bad   = 0;

  johnson_phase_decoder dut (
    .clock        (clock),
    .clear        (clear),
    .ring_in      (ring_in),
    .phase_idx    (phase_idx),
    .phase_onehot (phase_onehot),
    .valid_code   (valid_code),
    .locked       (locked),
    .wrap_pulse   (wrap_pulse),
    .rev_count    (rev_count),
    .err_pulse    (err_pulse),
    .corr_clear_n (corr_clear_n)
  );

  always #5 clock = ~clock;

  // Reference model state
  int         m_ph;
  bit         m_valid;
  bit         m_locked;
  bit         m_acq;
  int         m_run;
  int         m_rev;
  bit         e_wrap;
  bit         e_err;
  bit         e_corr;
  logic [5:0] pend;

  function automatic logic [5:0] phase_code(input int p);
    int v;
    if (p <= W) v = ((1 << p) - 1) << (W - p);
    else        v = (1 << (W - (p - W))) - 1;
    return 6'(v);
  endfunction

  function automatic int code_to_phase(input logic [5:0] c);
    for (int p = 0; p < P; p++)
      if (phase_code(p) == c) return p;
    return -1;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_valid = 0; m_locked = 0; m_acq = 0; m_run = 0; m_rev = 0;
    e_wrap = 0; e_err = 0; e_corr = 1; pend = '0;
  endtask

  task automatic model_step(input logic [5:0] c);
    int p;
    int d;
    p = code_to_phase(c);
    e_wrap = 0; e_err = 0; e_corr = 1;
    if (p < 0) begin
      if (m_locked) begin
        e_err = 1;
`ifdef JOHNSON_AUTOCORRECT_EN
        e_corr = 0;
`endif
      end
      m_locked = 0; m_acq = 0; m_run = 0; m_valid = 0;
    end else begin
      d = m_valid ? (p - m_ph + P) % P : -1;
      if (m_locked) begin
        if (d == 1 && m_ph == P - 1) begin
          e_wrap = 1;
          m_rev  = (m_rev + 1) % 256;
        end else if (d != 0 && d != 1) begin
          e_err = 1; m_locked = 0; m_run = 0;
        end
      end else if (m_acq) begin
        if (d == 1) begin
          m_run++;
          if (m_run >= LC) begin m_locked = 1; m_acq = 0; m_run = 0; end
        end else if (d != 0) begin
          m_acq = 0; m_run = 0;
        end
      end else begin
        m_acq = 1; m_run = 0;
      end
      m_ph = p; m_valid = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("phase_idx", 32'(phase_idx), 32'(m_ph));
    chk("phase_onehot", 32'(phase_onehot), m_valid ? (32'd1 << m_ph) : 32'd0);
    chk("valid_code", 32'(valid_code), 32'(m_valid));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("wrap_pulse", 32'(wrap_pulse), 32'(e_wrap));
    chk("rev_count", 32'(rev_count), 32'(m_rev));
    chk("err_pulse", 32'(err_pulse), 32'(e_err));
    chk("corr_clear_n", 32'(corr_clear_n), 32'(e_corr));
  endtask

  // The decode stage sees the code sampled one edge earlier (pend).
  task automatic drive(input logic [5:0] v);
    ring_in = v;
    @(posedge clock);
    #1;
    model_step(pend);
    check_all();
    pend = v;
  endtask

  task automatic drive_phase(input int p);
    drive(phase_code(p % P));
  endtask

  // Assert clear between edges and check that outputs drop with no clock.
  task automatic async_reset();
    #2 clear = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clock);
    clear = 1'b1;
  endtask

  task automatic random_run(input int n);
    int cur;
    int r;
    logic [5:0] c;
    cur = 0;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        cur = (cur + 1) % P; c = phase_code(cur);
      end else if (r < 82) begin
        c = phase_code(cur);
      end else if (r < 90) begin
        cur = $urandom_range(0, P - 1); c = phase_code(cur);
      end else begin
        c = 6'($urandom_range(0, 63));
        if (code_to_phase(c) >= 0) cur = code_to_phase(c);
      end
      drive(c);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all();
    @(negedge clock);
    clear = 1'b1;

    // Lock acquisition
    for (int p = 0; p <= 4; p++) drive_phase(p);
    chk("pre_lock_locked", 32'(locked), 32'd0);
    drive_phase(5);
    chk("lock_phase", 32'(phase_idx), 32'd4);
    chk("lock_locked", 32'(locked), 32'd1);

    // Wrap, then twelve more advances
    for (int p = 6; p <= 12; p++) drive_phase(p);
    drive_phase(1);
    chk("wrap_pulse_at_0", 32'(wrap_pulse), 32'd1);
    chk("rev_one", 32'(rev_count), 32'd1);
    for (int p = 2; p <= 12; p++) drive_phase(p);
    drive_phase(1);
    chk("rev_two", 32'(rev_count), 32'd2);

    // Hold at 111111
    for (int p = 2; p <= 6; p++) drive_phase(p);
    repeat (3) drive_phase(6);
    chk("hold_onehot", 32'(phase_onehot), 32'h040);
    chk("hold_locked", 32'(locked), 32'd1);

    // Illegal code while locked
    drive(6'b101010);
    drive_phase(0);
    chk("illegal_valid", 32'(valid_code), 32'd0);
    chk("illegal_phase", 32'(phase_idx), 32'd6);
    chk("illegal_err", 32'(err_pulse), 32'd1);

    // Relock, then a bad step 110000 -> 111100
    for (int p = 1; p <= 14; p++) drive_phase(p);
    drive_phase(4);
    drive_phase(4);
    chk("bad_step_err", 32'(err_pulse), 32'd1);
    chk("bad_step_phase", 32'(phase_idx), 32'd4);
    chk("bad_step_corr", 32'(corr_clear_n), 32'd1);

    // Async reset mid-stream, then relock from scratch
    for (int p = 5; p <= 12; p++) drive_phase(p);
    async_reset();
    for (int p = 0; p <= 3; p++) drive_phase(p);
    drive_phase(4);
    chk("relock_three", 32'(locked), 32'd0);
    drive_phase(5);
    chk("relock_four", 32'(locked), 32'd1);

    // Randomized traffic with a reset in the middle
    random_run(300);
    async_reset();
    random_run(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
